// File: rtl/traffic_fsm_pkg.sv
// Shared types and constants for the main/side-street traffic controller.
package traffic_fsm_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN     = 3'd0,
        MAIN_GREEN_EXT = 3'd1,
        MAIN_YELLOW    = 3'd2,
        PED_WALK       = 3'd3,
        SIDE_GREEN     = 3'd4,
        SIDE_GREEN_EXT = 3'd5,
        SIDE_YELLOW    = 3'd6,
        ILLEGAL        = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        SEL_BASE = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_YEL  = 2'b10,
        SEL_NONE = 2'b11
    } sel_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [3:0] BASE_DEFAULT = 4'd6;
    localparam logic [3:0] EXT_DEFAULT  = 4'd3;
    localparam logic [3:0] YEL_DEFAULT  = 4'd2;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } lights_t;

    function automatic sel_e interval_of(input state_e s);
        case (s)
            MAIN_GREEN, SIDE_GREEN:                return SEL_BASE;
            MAIN_GREEN_EXT, SIDE_GREEN_EXT, PED_WALK: return SEL_EXT;
            MAIN_YELLOW, SIDE_YELLOW:              return SEL_YEL;
            default:                               return SEL_BASE;
        endcase
    endfunction

    // Unknown codes show all-red so a corrupted state can never show a conflicting green.
    function automatic lights_t lights_of(input state_e s);
        case (s)
            MAIN_GREEN, MAIN_GREEN_EXT: return '{main: GRN, side: RED, walk: 1'b0};
            MAIN_YELLOW:                return '{main: YEL, side: RED, walk: 1'b0};
            PED_WALK:                   return '{main: RED, side: RED, walk: 1'b1};
            SIDE_GREEN, SIDE_GREEN_EXT: return '{main: RED, side: GRN, walk: 1'b0};
            SIDE_YELLOW:                return '{main: RED, side: YEL, walk: 1'b0};
            default:                    return '{main: RED, side: RED, walk: 1'b0};
        endcase
    endfunction

endpackage

// File: rtl/traffic_fsm_time_params.sv
// Three programmable 4-bit phase intervals; writing zero restores that entry's default.
module time_params
    import traffic_fsm_pkg::*;
#(
    parameter logic [3:0] BASE_DEF = BASE_DEFAULT,
    parameter logic [3:0] EXT_DEF  = EXT_DEFAULT,
    parameter logic [3:0] YEL_DEF  = YEL_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       we_i,
    input  sel_e       wsel_i,
    input  logic [3:0] wvalue_i,
    input  sel_e       rsel_i,
    output logic [3:0] rvalue_o
);

    logic [3:0] base_q;
    logic [3:0] ext_q;
    logic [3:0] yel_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            base_q <= BASE_DEF;
            ext_q  <= EXT_DEF;
            yel_q  <= YEL_DEF;
        end else if (we_i) begin
            case (wsel_i)
                SEL_BASE: base_q <= (wvalue_i == 4'd0) ? BASE_DEF : wvalue_i;
                SEL_EXT:  ext_q  <= (wvalue_i == 4'd0) ? EXT_DEF  : wvalue_i;
                SEL_YEL:  yel_q  <= (wvalue_i == 4'd0) ? YEL_DEF  : wvalue_i;
                default:  ;
            endcase
        end
    end

    always_comb begin
        case (rsel_i)
            SEL_EXT: rvalue_o = ext_q;
            SEL_YEL: rvalue_o = yel_q;
            default: rvalue_o = base_q;
        endcase
    end

endmodule

// File: rtl/traffic_fsm.sv
// Intersection phase sequencer driving the countdown timer, both light heads and the walk lamp.
//   state          | meaning
//   MAIN_GREEN/EXT | main street green, base then optional extension
//   MAIN_YELLOW    | main clearing; PED_WALK next if a walk is pending
//   PED_WALK       | all red, walk lamp on
//   SIDE_GREEN/EXT | side street green, extension only while a car waits
//   SIDE_YELLOW    | side clearing, back to MAIN_GREEN
module traffic_fsm
    import traffic_fsm_pkg::*;
#(
    parameter logic [3:0] T_BASE_DEF = BASE_DEFAULT,
    parameter logic [3:0] T_EXT_DEF  = EXT_DEFAULT,
    parameter logic [3:0] T_YEL_DEF  = YEL_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    output logic [3:0] timer_value,
    output logic       start_timer,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp,
    output logic [2:0] state_dbg
);

    state_e  state_q, state_d;
    logic    entry_q, entry_d;
    logic    walk_pending_q, walk_pending_d;
    lights_t lights_q;
    logic [3:0] interval;

    time_params #(
        .BASE_DEF (T_BASE_DEF),
        .EXT_DEF  (T_EXT_DEF),
        .YEL_DEF  (T_YEL_DEF)
    ) u_time_params (
        .clock    (clock),
        .reset    (reset),
        .we_i     (reprogram),
        .wsel_i   (sel_e'(time_param_sel)),
        .wvalue_i (time_value),
        .rsel_i   (interval_of(state_q)),
        .rvalue_o (interval)
    );

    always_comb begin
        state_d        = state_q;
        entry_d        = 1'b0;
        // A request landing in the PED_WALK entry cycle must survive for the next cycle round.
        walk_pending_d = walk_request |
                         (walk_pending_q & ~(entry_q & (state_q == PED_WALK)));
        if (reprogram || state_q == ILLEGAL) begin
            state_d = MAIN_GREEN;
            entry_d = 1'b1;
        end else if (!entry_q && expired) begin
            entry_d = 1'b1;
            case (state_q)
                MAIN_GREEN:     state_d = sensor ? MAIN_YELLOW : MAIN_GREEN_EXT;
                MAIN_GREEN_EXT: state_d = MAIN_YELLOW;
                MAIN_YELLOW:    state_d = walk_pending_q ? PED_WALK : SIDE_GREEN;
                PED_WALK:       state_d = SIDE_GREEN;
                SIDE_GREEN:     state_d = sensor ? SIDE_GREEN_EXT : SIDE_YELLOW;
                SIDE_GREEN_EXT: state_d = SIDE_YELLOW;
                default:        state_d = MAIN_GREEN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= MAIN_GREEN;
            entry_q        <= 1'b1;
            walk_pending_q <= 1'b0;
            lights_q       <= lights_of(MAIN_GREEN);
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            walk_pending_q <= walk_pending_d;
            lights_q       <= lights_of(state_d);
        end
    end

    // Timer is held in reset alongside us, so no load strobe until reset drops.
    assign start_timer = entry_q & ~reset;
    assign timer_value = interval;
    assign main_lights = lights_q.main;
    assign side_lights = lights_q.side;
    assign walk_lamp   = lights_q.walk;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm with a behavioural countdown timer on start_timer/expired.
module tb_traffic_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_sel = 2'b11;
    logic [3:0] time_value = 4'd0;
    logic       expired;
    logic [3:0] timer_value;
    logic       start_timer;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic       hold_exp = 1'b0;
    logic [3:0] tcnt = 4'hF;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] tv;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wl;
    } exp_t;

    exp_t exp_q[$];

    traffic_fsm dut (
        .clock          (clock),
        .reset          (reset),
        .sensor         (sensor),
        .walk_request   (walk_request),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .expired        (expired),
        .timer_value    (timer_value),
        .start_timer    (start_timer),
        .main_lights    (main_lights),
        .side_lights    (side_lights),
        .walk_lamp      (walk_lamp),
        .state_dbg      (state_dbg)
    );

    always #5 clock = ~clock;

    // Countdown timer model: loads on start_timer, flags expired at zero.
    always @(posedge clock) begin
        if (reset)            tcnt <= 4'hF;
        else if (start_timer) tcnt <= timer_value;
        else if (tcnt != 0)   tcnt <= tcnt - 4'd1;
    end
    assign expired = hold_exp | (tcnt == 4'd0);

    function automatic exp_t mk(input logic [2:0] st, input logic [3:0] tv);
        exp_t e;
        e.st = st;
        e.tv = tv;
        e.wl = 1'b0;
        case (st)
            3'd0, 3'd1: begin e.ml = 3'b001; e.sl = 3'b100; end
            3'd2:       begin e.ml = 3'b010; e.sl = 3'b100; end
            3'd3:       begin e.ml = 3'b100; e.sl = 3'b100; e.wl = 1'b1; end
            3'd4, 3'd5: begin e.ml = 3'b100; e.sl = 3'b001; end
            default:    begin e.ml = 3'b100; e.sl = 3'b010; end
        endcase
        return e;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("st=%0d tv=%0d main=%b side=%b walk=%b", v.st, v.tv, v.ml, v.sl, v.wl);
    endfunction

    function automatic exp_t observe();
        return {state_dbg, timer_value, main_lights, side_lights, walk_lamp};
    endfunction

    task automatic push(input logic [2:0] st, input logic [3:0] tv);
        exp_q.push_back(mk(st, tv));
    endtask

    task automatic test_reset();
        exp_t obs;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        obs = observe();
        n_cmp++;
        if (obs !== mk(3'd0, 4'd6)) begin
            n_bad++;
            $display("FAIL reset_outputs got %s want %s", fmt(obs), fmt(mk(3'd0, 4'd6)));
        end
        n_cmp++;
        if (start_timer !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_start got %b want 0", start_timer);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (start_timer !== 1'b1 || timer_value !== 4'd6) begin
            n_bad++;
            $display("FAIL reset_release got start=%b tv=%0d want start=1 tv=6", start_timer, timer_value);
        end
    endtask

    task automatic test_sequence();
        exp_t e, obs;
        logic prev;
        sensor = 1'b0;
        push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd4, 4'd6); push(3'd6, 4'd2); push(3'd0, 4'd6);
        prev = 1'b0;
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL seq_state got %s want %s", fmt(obs), fmt(e)); end
                n_cmp++;
                if (prev !== 1'b0) begin n_bad++; $display("FAIL seq_start_width got two-cycle start at st=%0d want one", state_dbg); end
            end
            prev = start_timer;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL seq_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sensor();
        exp_t e, obs;
        logic prev;
        sensor = 1'b1;
        push(3'd2, 4'd2); push(3'd4, 4'd6); push(3'd5, 4'd3); push(3'd6, 4'd2); push(3'd0, 4'd6);
        prev = 1'b0;
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL sensor_state got %s want %s", fmt(obs), fmt(e)); end
                n_cmp++;
                if (prev !== 1'b0) begin n_bad++; $display("FAIL sensor_start_width got two-cycle start at st=%0d want one", state_dbg); end
            end
            prev = start_timer;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sensor_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        sensor = 1'b0;
    endtask

    task automatic test_walk();
        exp_t e, obs;
        @(negedge clock);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd3, 4'd3); push(3'd4, 4'd6); push(3'd6, 4'd2);
        push(3'd0, 4'd6); push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd4, 4'd6); push(3'd6, 4'd2);
        push(3'd0, 4'd6);
        for (int c = 0; c < 900 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL walk_state got %s want %s", fmt(obs), fmt(e)); end
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL walk_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, obs;
        int gap;
        int ped_hits;
        sensor = 1'b0;
        hold_exp = 1'b1;
        walk_request = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd3, 4'd3);
            push(3'd4, 4'd6); push(3'd6, 4'd2); push(3'd0, 4'd6);
        end
        push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd4, 4'd6); push(3'd6, 4'd2); push(3'd0, 4'd6);
        gap = 0;
        ped_hits = 0;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            walk_request = 1'b0;
            gap++;
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL b2b_state got %s want %s", fmt(obs), fmt(e)); end
                n_cmp++;
                if (gap != 2) begin n_bad++; $display("FAIL b2b_dwell got %0d cycles want 2 before st=%0d", gap, state_dbg); end
                gap = 0;
                if (state_dbg == 3'd3) begin
                    if (ped_hits == 0) walk_request = 1'b1;
                    ped_hits++;
                end
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b2b_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        hold_exp = 1'b0;
        walk_request = 1'b0;
    endtask

    task automatic test_reprogram();
        exp_t e, obs;
        sensor = 1'b0;
        push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd4, 4'd6);
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL reprog_pre got %s want %s", fmt(obs), fmt(e)); end
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL reprog_pre_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        // In SIDE_GREEN entry cycle: BASE <= 9
        time_param_sel = 2'b00; time_value = 4'd9; reprogram = 1'b1;
        @(posedge clock); #1 reprogram = 1'b0;
        @(negedge clock);
        obs = observe();
        n_cmp++;
        if (obs !== mk(3'd0, 4'd9) || start_timer !== 1'b1) begin
            n_bad++;
            $display("FAIL reprog_base9 got %s start=%b want %s start=1", fmt(obs), start_timer, fmt(mk(3'd0, 4'd9)));
        end
        @(negedge clock);
        // BASE <= default while expired is also high
        time_param_sel = 2'b00; time_value = 4'd0; reprogram = 1'b1; hold_exp = 1'b1;
        @(posedge clock); #1 reprogram = 1'b0; hold_exp = 1'b0;
        @(negedge clock);
        obs = observe();
        n_cmp++;
        if (obs !== mk(3'd0, 4'd6) || start_timer !== 1'b1) begin
            n_bad++;
            $display("FAIL reprog_default got %s start=%b want %s start=1", fmt(obs), start_timer, fmt(mk(3'd0, 4'd6)));
        end
        @(negedge clock);
        time_param_sel = 2'b11; time_value = 4'd5; reprogram = 1'b1;
        @(posedge clock); #1 reprogram = 1'b0;
        @(negedge clock);
        obs = observe();
        n_cmp++;
        if (obs !== mk(3'd0, 4'd6) || start_timer !== 1'b1) begin
            n_bad++;
            $display("FAIL reprog_none got %s start=%b want %s start=1", fmt(obs), start_timer, fmt(mk(3'd0, 4'd6)));
        end
        push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd4, 4'd6); push(3'd6, 4'd2); push(3'd0, 4'd6);
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL reprog_post got %s want %s", fmt(obs), fmt(e)); end
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL reprog_post_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, obs;
        sensor = 1'b0;
        @(negedge clock);
        time_param_sel = 2'b10; time_value = 4'd5; reprogram = 1'b1;
        @(posedge clock); #1 reprogram = 1'b0;
        @(negedge clock);
        obs = observe();
        n_cmp++;
        if (obs !== mk(3'd0, 4'd6) || start_timer !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_restart got %s start=%b want %s start=1", fmt(obs), start_timer, fmt(mk(3'd0, 4'd6)));
        end
        push(3'd1, 4'd3); push(3'd2, 4'd5); push(3'd4, 4'd6); push(3'd6, 4'd5);
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            walk_request = 1'b0;
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL rmid_pre got %s want %s", fmt(obs), fmt(e)); end
                if (state_dbg == 3'd4) walk_request = 1'b1;
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rmid_pre_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
        walk_request = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        obs = observe();
        n_cmp++;
        if (obs !== mk(3'd0, 4'd6) || start_timer !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_reset got %s start=%b want %s start=0", fmt(obs), start_timer, fmt(mk(3'd0, 4'd6)));
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (start_timer !== 1'b1 || timer_value !== 4'd6) begin
            n_bad++;
            $display("FAIL rmid_release got start=%b tv=%0d want start=1 tv=6", start_timer, timer_value);
        end
        push(3'd1, 4'd3); push(3'd2, 4'd2); push(3'd4, 4'd6);
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) begin
            @(negedge clock);
            if (start_timer === 1'b1) begin
                e = exp_q.pop_front();
                obs = observe();
                n_cmp++;
                if (obs !== e) begin n_bad++; $display("FAIL rmid_post got %s want %s", fmt(obs), fmt(e)); end
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rmid_post_timeout got %0d states pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_sensor();
        test_walk();
        test_back_to_back();
        test_reprogram();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
